// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the system-ID slave.
// Handshake: a read is accepted on a rising clock edge where avm_read=1 and
// avm_waitrequest=0; avm_readdata is valid only in that cycle, and the master holds
// avm_address/avm_read stable while it is stalled.
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID and timestamp words after reset or on request, checks them
// against build-time values with bounded retries, and latches sticky status.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1493023976,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_boot_checker_if.master   avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   id_mismatch,
    output logic                   ts_mismatch,
    output logic                   timeout,
    output logic [3:0]             attempts,
    output logic [31:0]            captured_id,
    output logic [31:0]            captured_ts,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  RETRY_MAX  = 5'(MAX_RETRIES);

    state_t      r_state,     w_state_nxt;
    logic        r_auto_start, w_auto_start_nxt;
    logic        r_read,      w_read_nxt;
    logic        r_addr,      w_addr_nxt;
    logic        r_busy,      w_busy_nxt;
    logic        r_done,      w_done_nxt;
    logic        r_pass,      w_pass_nxt;
    logic        r_id_mm,     w_id_mm_nxt;
    logic        r_ts_mm,     w_ts_mm_nxt;
    logic        r_timeout,   w_timeout_nxt;
    logic        r_timed_out, w_timed_out_nxt;
    logic [3:0]  r_attempts,  w_attempts_nxt;
    logic [15:0] r_stall,     w_stall_nxt;
    logic [31:0] r_cap_id,    w_cap_id_nxt;
    logic [31:0] r_cap_ts,    w_cap_ts_nxt;

    logic w_id_bad, w_ts_bad, w_retry_ok, w_start_seq;

    assign w_id_bad    = (r_cap_id != EXPECTED_ID);
    assign w_ts_bad    = (r_cap_ts != EXPECTED_TIMESTAMP);
    assign w_retry_ok  = ({1'b0, r_attempts} <= RETRY_MAX);
    assign w_start_seq = ((r_state == S_IDLE) && (r_auto_start || start)) ||
                         ((r_state == S_DONE) && start);

    always_comb begin
        w_state_nxt      = r_state;
        w_auto_start_nxt = r_auto_start;
        w_read_nxt       = r_read;
        w_addr_nxt       = r_addr;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_pass_nxt       = r_pass;
        w_id_mm_nxt      = r_id_mm;
        w_ts_mm_nxt      = r_ts_mm;
        w_timeout_nxt    = r_timeout;
        w_timed_out_nxt  = r_timed_out;
        w_attempts_nxt   = r_attempts;
        w_stall_nxt      = r_stall;
        w_cap_id_nxt     = r_cap_id;
        w_cap_ts_nxt     = r_cap_ts;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_seq) begin
                    w_state_nxt      = S_RD_ID;
                    w_auto_start_nxt = 1'b0;
                    w_read_nxt       = 1'b1;
                    w_addr_nxt       = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_done_nxt       = 1'b0;
                    w_pass_nxt       = 1'b0;
                    w_id_mm_nxt      = 1'b0;
                    w_ts_mm_nxt      = 1'b0;
                    w_timeout_nxt    = 1'b0;
                    w_timed_out_nxt  = 1'b0;
                    w_attempts_nxt   = 4'd1;
                    w_stall_nxt      = 16'd0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    w_stall_nxt = 16'd0;
                    if (r_state == S_RD_ID) begin
                        w_cap_id_nxt = avm.avm_readdata;
                        w_addr_nxt   = 1'b1;
                        w_state_nxt  = S_RD_TS;
                    end else begin
                        w_cap_ts_nxt = avm.avm_readdata;
                        w_read_nxt   = 1'b0;
                        w_state_nxt  = S_CHECK;
                    end
                end else if (r_stall == STALL_LAST) begin
                    // Abort: CHECK doubles as the one idle cycle before any re-issue.
                    w_read_nxt      = 1'b0;
                    w_timed_out_nxt = 1'b1;
                    w_state_nxt     = S_CHECK;
                end else begin
                    w_stall_nxt = r_stall + 16'd1;
                end
            end
            S_CHECK: begin
                if (!r_timed_out && !w_id_bad && !w_ts_bad) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b1;
                end else if (w_retry_ok) begin
                    w_state_nxt     = S_RD_ID;
                    w_read_nxt      = 1'b1;
                    w_addr_nxt      = 1'b0;
                    w_attempts_nxt  = r_attempts + 4'd1;
                    w_stall_nxt     = 16'd0;
                    w_timed_out_nxt = 1'b0;
                end else begin
                    w_state_nxt     = S_DONE;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_timeout_nxt   = r_timed_out;
                    w_id_mm_nxt     = !r_timed_out && w_id_bad;
                    w_ts_mm_nxt     = !r_timed_out && w_ts_bad;
                    w_timed_out_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_auto_start <= 1'b1;
            r_read       <= 1'b0;
            r_addr       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_id_mm      <= 1'b0;
            r_ts_mm      <= 1'b0;
            r_timeout    <= 1'b0;
            r_timed_out  <= 1'b0;
            r_attempts   <= 4'd0;
            r_stall      <= 16'd0;
            r_cap_id     <= 32'd0;
            r_cap_ts     <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_auto_start <= w_auto_start_nxt;
            r_read       <= w_read_nxt;
            r_addr       <= w_addr_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_id_mm      <= w_id_mm_nxt;
            r_ts_mm      <= w_ts_mm_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timed_out  <= w_timed_out_nxt;
            r_attempts   <= w_attempts_nxt;
            r_stall      <= w_stall_nxt;
            r_cap_id     <= w_cap_id_nxt;
            r_cap_ts     <= w_cap_ts_nxt;
        end
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign id_mismatch     = r_id_mm;
    assign ts_mismatch     = r_ts_mm;
    assign timeout         = r_timeout;
    assign attempts        = r_attempts;
    assign captured_id     = r_cap_id;
    assign captured_ts     = r_cap_ts;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: directed sequences against a behavioural ID slave,
// expected outcomes queued at stimulus time and checked whenever done rises.
module tb_sysid_boot_checker;
  localparam int W = 104;
  localparam logic [31:0] TS_GOOD = 32'd1493023976;
  localparam logic [31:0] TS_BAD  = 32'h12345678;
  localparam logic [31:0] ID_BAD  = 32'hCAFE0001;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [3:0]  attempts;
  logic [31:0] captured_id, captured_ts;
  logic [2:0]  dbg_state;

  sysid_boot_checker_if avm_if ();

  sysid_boot_checker #(
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .avm         (avm_if),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_mismatch (id_mismatch),
    .ts_mismatch (ts_mismatch),
    .timeout     (timeout),
    .attempts    (attempts),
    .captured_id (captured_id),
    .captured_ts (captured_ts),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cyc = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // behavioural system-ID slave
  logic [31:0] id_val, ts_val;
  int          stall_id, stall_ts, wait_cnt, stall_now;
  bit          stuck;
  logic        prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;

  always @(negedge clock) begin
    if (prev_read && prev_wait && avm_if.avm_read)
      chk("hold_addr", 32'(avm_if.avm_address), 32'(prev_addr));
    if (prev_read && !prev_wait) wait_cnt = 0;
    else if (prev_read)          wait_cnt++;
    else                         wait_cnt = 0;
    stall_now = avm_if.avm_address ? stall_ts : stall_id;
    avm_if.avm_waitrequest = avm_if.avm_read && (stuck || (wait_cnt < stall_now));
    avm_if.avm_readdata    = !avm_if.avm_read ? 32'hDEADBEEF :
                             (avm_if.avm_address ? ts_val : id_val);
    prev_read = avm_if.avm_read;
    prev_wait = avm_if.avm_waitrequest;
    prev_addr = avm_if.avm_address;
  end

  // scoreboard monitor: one expected entry per completed sequence
  logic         done_q = 1'b0;
  logic [W-1:0] e;
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no sequence (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle",  32'(cyc), e[103:72]);
        chk("attempts",    32'(attempts), 32'(e[71:68]));
        chk("flags_p_i_t_o", 32'({pass, id_mismatch, ts_mismatch, timeout}), 32'(e[67:64]));
        chk("captured_id", captured_id, e[63:32]);
        chk("captured_ts", captured_ts, e[31:0]);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    done_q = done;
  end

  // driver tasks
  task automatic push_exp(input int lat, input logic [3:0] att, input logic [3:0] flags,
                          input logic [31:0] cid, input logic [31:0] cts);
    exp_q.push_back({32'(start_cyc + lat), att, flags, cid, cts});
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
    chk("start_busy",     32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_flags_clr", 32'({pass, id_mismatch, ts_mismatch, timeout}), 32'd0);
    chk("start_attempts", 32'(attempts), 32'd1);
  endtask

  task automatic wait_seq(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL seq_timeout: got %0d pending expected 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    start = 1'b0;
    id_val = 32'd0;
    ts_val = TS_GOOD;
    stall_id = 0;
    stall_ts = 0;
    stuck = 1'b0;
    wait_cnt = 0;
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata = 32'd0;
    repeat (3) @(negedge clock);

    chk("rst_read",     32'(avm_if.avm_read), 32'd0);
    chk("rst_addr",     32'(avm_if.avm_address), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_flags",    32'({pass, id_mismatch, ts_mismatch, timeout}), 32'd0);
    chk("rst_attempts", 32'(attempts), 32'd0);
    chk("rst_cap_id",   captured_id, 32'd0);
    chk("rst_cap_ts",   captured_ts, 32'd0);

    // auto check after reset release, zero wait states
    reset_n = 1'b1;
    start_cyc = cyc;
    push_exp(4, 4'd1, 4'b1000, 32'd0, TS_GOOD);
    @(negedge clock);
    chk("t1_addr_first", 32'(avm_if.avm_address), 32'd0);
    chk("t1_read_first", 32'(avm_if.avm_read), 32'd1);
    @(negedge clock);
    chk("t1_addr_second", 32'(avm_if.avm_address), 32'd1);
    wait_seq(40);

    // five wait states on the ID read
    stall_id = 5;
    do_start();
    push_exp(9, 4'd1, 4'b1000, 32'd0, TS_GOOD);
    wait_seq(40);
    stall_id = 0;

    // timestamp always wrong: all retries used
    ts_val = TS_BAD;
    do_start();
    push_exp(13, 4'd4, 4'b0010, 32'd0, TS_BAD);
    wait_seq(60);

    // both words wrong
    id_val = ID_BAD;
    do_start();
    push_exp(13, 4'd4, 4'b0110, ID_BAD, TS_BAD);
    wait_seq(60);
    id_val = 32'd0;
    ts_val = TS_GOOD;

    // slave stuck in waitrequest: every attempt times out, captures untouched
    stuck = 1'b1;
    do_start();
    push_exp(37, 4'd4, 4'b0001, ID_BAD, TS_BAD);
    wait_seq(100);

    // first attempt times out, second succeeds
    do_start();
    push_exp(13, 4'd2, 4'b1000, 32'd0, TS_GOOD);
    k = 0;
    while (k < 40 && !(busy && !avm_if.avm_read)) begin
      @(negedge clock);
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_fail++;
      $display("FAIL abort_wait: got no read drop expected one within 40 cycles");
    end
    stuck = 1'b0;
    wait_seq(60);

    // start during RD_TS is ignored
    do_start();
    push_exp(4, 4'd1, 4'b1000, 32'd0, TS_GOOD);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start_attempts", 32'(attempts), 32'd1);
    wait_seq(40);

    // reset during RD_TS clears everything asynchronously, then auto re-run
    do_start();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_read",     32'(avm_if.avm_read), 32'd0);
    chk("midrst_busy",     32'(busy), 32'd0);
    chk("midrst_attempts", 32'(attempts), 32'd0);
    chk("midrst_cap_ts",   captured_ts, 32'd0);
    chk("midrst_addr",     32'(avm_if.avm_address), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    start_cyc = cyc;
    push_exp(4, 4'd1, 4'b1000, 32'd0, TS_GOOD);
    wait_seq(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
